slave_mem: RTL and testbench
============================

# slave_mem

Synthesizable memory responder for one slave port of `cross_bar`. It is the responder end of the req/cmd/addr/wdata → ack/rdata protocol. It captures a request, waits a programmable ack latency, then performs a word write or read into a local register array and pulses `ack` for one cycle. One instance attaches to each cross_bar `slave_N_*` port set and replaces the behavioural slave models in system benches.

## Interface
- `ADDR_W`, default 8: word-index bits; depth = 2^ADDR_W words of 32 bits.
- `ACK_DELAY`, default 1: cycles from request accept to `ack` rise; legal range 1..15.
- `PCLK` in 1: clock, all logic on the rising edge.
- `PRESETN` in 1: reset, asynchronous, active-low.
- `req` in 1: request; held high across a burst.
- `cmd` in 1: 1 = write, 0 = read.
- `addr` in 32: word address; only `addr[ADDR_W-1:0]` decoded, upper bits ignored (alias).
- `wdata` in 32: write data.
- `ack` out 1: one-cycle completion pulse.
- `rdata` out 32: read data; valid from `ack` rise, held until the next read completes.

## Operation
- FSM states: IDLE, WAIT, ACK.
- IDLE: at an edge with `req`=1:
  - capture `cmd`, `addr[ADDR_W-1:0]` and `wdata` into internal registers;
  - load `cnt` = delay−1;
  - go to WAIT.
- WAIT:
  - `cnt`≠0: decrement.
  - `cnt`=0: go to ACK and set `ack`=1.
  - On that same edge, a write stores the captured `wdata` into mem[idx]; a read loads `rdata` ← mem[idx].
- ACK: `ack`=0 on the next edge, return to IDLE. No accept happens on this edge.
- Burst: the master keeps `req` high and updates `addr`/`wdata` on the edge after `ack` rise. The block re-samples them at the following edge. Each beat is an independent transaction.
- `req` dropping during WAIT does not abort; the captured transaction completes and acks.
- `cmd`/`addr`/`wdata` changes after accept are ignored until the next accept.
- Writes do not change `rdata`.
- A read of a word written earlier returns the latest written value. Read-after-write to the same word across consecutive bursts needs no bypass, since the write completes before the next accept.

## Timing
- Reset values:
  - `ack`=0, `rdata`=32'h0, state IDLE, `cnt`=0;
  - all memory words 32'h0;
  - LFSR = 16'hACE1 (when enabled).
- Reset asserted mid-transaction: `ack` drops immediately (asynchronous). The pending write is discarded and memory is cleared.
- Accept at edge E0 → `ack` high from edge E0+D to E0+D+1, where D is the effective delay.
- Earliest next accept is E0+D+2, so one idle cycle separates `ack` from the next accept.
- Burst throughput: one beat per D+2 cycles. With D=1, back-to-back beats accept at E0, E0+3, E0+6, …
- `rdata` is registered and changes only at a read `ack` rise edge.
- `ack` is never high in two consecutive cycles.

## Configuration
- `SLAVE_MEM_RANDOM_DELAY_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) advances every cycle, including while idle.
  - At accept, D = 1 + lfsr[1:0], giving a 1..4 cycle latency per beat. `ACK_DELAY` is ignored.
  - Used to stress cross_bar arbitration with variable latency.
- Not defined: no LFSR logic is present and D = `ACK_DELAY` for every transaction.

## Test plan
- Reset value check: hold PRESETN low 3 cycles, release → `ack`=0, `rdata`=0. A read of addr 0x10 returns 0x00000000.
- Single write then read, ACK_DELAY=1:
  - Write addr 0x0000_0005, wdata 0xDEADBEEF, accepted at E0 → `ack` pulses exactly at E0+1 for one cycle.
  - Separate read of addr 0x8000_0005 (aliased) → `rdata`=0xDEADBEEF at its `ack` rise.
- Burst write of 4 beats, req held high, addr 0x20..0x23, data 0x11,0x22,0x33,0x44 → four one-cycle acks spaced 3 cycles apart. A read burst of 0x20..0x23 returns 0x11,0x22,0x33,0x44 in order.
- ACK_DELAY=4: read addr 0x3 → `ack` rises exactly 4 cycles after accept. Dropping `req` 1 cycle after accept still yields one ack and updates `rdata`.
- Reset mid-operation: during WAIT of a write to 0x7 with 0xCAFEF00D, pulse PRESETN low → `ack` stays 0, state IDLE, and a subsequent read of 0x7 returns 0.
- With `SLAVE_MEM_RANDOM_DELAY_EN`: 50 random read/write beats → every ack latency is in 1..4, all read data matches the scoreboard, and no two consecutive ack-high cycles occur.

Source files
------------

// File: rtl/slave_mem_if.sv
// rtl/slave_mem_if.sv - request/acknowledge bus between a cross_bar slave port and slave_mem
//
// Purpose: groups the req/cmd/addr/wdata -> ack/rdata handshake of one
// cross_bar slave port set so a responder can attach with a single port.
// Signals:
//   req    master->slave  request, held high across a burst
//   cmd    master->slave  1 = write, 0 = read
//   addr   master->slave  32-bit word address
//   wdata  master->slave  32-bit write data
//   ack    slave->master  one-cycle completion pulse
//   rdata  slave->master  32-bit read data, valid from ack rise
interface slave_mem_if;
   logic        req;
   logic        cmd;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ack;
   logic [31:0] rdata;

   modport master (output req, cmd, addr, wdata, input ack, rdata);
   modport slave  (input req, cmd, addr, wdata, output ack, rdata);
endinterface

// File: rtl/slave_mem.sv
// rtl/slave_mem.sv - memory responder for one cross_bar slave port
//
// Purpose: accepts a request, waits an ack latency, then performs a 32-bit
// word write or read on a local 2^ADDR_W-word register array and pulses ack
// for one cycle. Only addr[ADDR_W-1:0] is decoded; upper bits alias.
// Ports:
//   PCLK     in   clock, rising edge
//   PRESETN  in   asynchronous active-low reset (clears memory too)
//   slv      slave_mem_if.slave  req/cmd/addr/wdata in, ack/rdata out
// Parameters:
//   ADDR_W     word-index bits (depth 2^ADDR_W)
//   ACK_DELAY  accept-to-ack latency in cycles, 1..15
// Build option:
//   SLAVE_MEM_RANDOM_DELAY_EN  when defined, a 16-bit LFSR picks a 1..4
//                              cycle latency per beat and ACK_DELAY is unused
module slave_mem #(
   parameter int ADDR_W    = 8,
   parameter int ACK_DELAY = 1
) (
   input logic        PCLK,
   input logic        PRESETN,
   slave_mem_if.slave slv
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              ack_q, ack_d;
   logic              cmd_q;
   logic [ADDR_W-1:0] idx_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;
   logic [31:0]       mem_q [DEPTH];
   logic              accept;
   logic              xfer;
   logic [3:0]        delay_m1;

`ifdef SLAVE_MEM_RANDOM_DELAY_EN
   // Fibonacci LFSR, taps 16,14,13,11; free-running so the latency seen by
   // a beat depends on when it arrives, not just on how many beats preceded it.
   logic [15:0] lfsr_q, lfsr_d;

   assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign delay_m1 = {2'b00, lfsr_q[1:0]};
`else
   assign delay_m1 = 4'(ACK_DELAY - 1);
`endif

   // Upper address bits alias onto the same words and are deliberately dropped.
   generate
      if (ADDR_W < 32) begin : g_alias
         logic unused_addr_hi;
         assign unused_addr_hi = ^slv.addr[31:ADDR_W];
      end
   endgenerate

   // Next-state logic. cnt holds remaining WAIT cycles minus one, so ack
   // rises exactly D edges after accept.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ack_d   = 1'b0;
      accept  = 1'b0;
      xfer    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (slv.req) begin
               accept  = 1'b1;
               cnt_d   = delay_m1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               xfer    = 1'b1;
               ack_d   = 1'b1;
               state_d = S_ACK;
            end
         end
         S_ACK: begin
            // No accept here: guarantees an idle cycle between ack pulses.
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         ack_q   <= 1'b0;
         cmd_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         if (accept) begin
            cmd_q   <= slv.cmd;
            idx_q   <= slv.addr[ADDR_W-1:0];
            wdata_q <= slv.wdata;
         end
         if (xfer && !cmd_q) begin
            rdata_q <= mem_q[idx_q];
         end
      end
   end

   // Memory is cleared by reset so a write interrupted by reset leaves no trace.
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 32'h0;
         end
      end else if (xfer && cmd_q) begin
         mem_q[idx_q] <= wdata_q;
      end
   end

   assign slv.ack   = ack_q;
   assign slv.rdata = rdata_q;

endmodule

// File: tb/tb_slave_mem.sv
// tb/tb_slave_mem.sv - self-checking bench for slave_mem with ACK_DELAY 1 and 4
module tb_slave_mem;
`ifdef SLAVE_MEM_RANDOM_DELAY_EN
   localparam bit RAND_D = 1'b1;
`else
   localparam bit RAND_D = 1'b0;
`endif

   logic PCLK = 1'b0;
   logic PRESETN = 1'b0;
   always #5 PCLK = ~PCLK;

   slave_mem_if m1 ();
   slave_mem_if m4 ();

   slave_mem #(.ADDR_W(8), .ACK_DELAY(1)) dut1 (.PCLK(PCLK), .PRESETN(PRESETN), .slv(m1.slave));
   slave_mem #(.ADDR_W(8), .ACK_DELAY(4)) dut4 (.PCLK(PCLK), .PRESETN(PRESETN), .slv(m4.slave));

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int dbl_ack = 0;
   logic prev1 = 1'b0;
   logic prev4 = 1'b0;
   logic [31:0] ref1 [256];
   logic [31:0] ref4 [256];
   logic [31:0] last_rd1;
   logic [31:0] last_rd4;

   always @(posedge PCLK) cyc <= cyc + 1;

   always @(negedge PCLK) begin
      if (prev1 && m1.ack) dbl_ack++;
      if (prev4 && m4.ack) dbl_ack++;
      prev1 = m1.ack;
      prev4 = m4.ack;
   end

   function automatic bit lat_ok(input int lat, input int d);
      if (RAND_D) return (lat >= 1 && lat <= 4);
      return (lat == d);
   endfunction

   task automatic clear_refs();
      for (int i = 0; i < 256; i++) begin
         ref1[i] = 32'h0;
         ref4[i] = 32'h0;
      end
      last_rd1 = 32'h0;
      last_rd4 = 32'h0;
   endtask

   // One beat from an IDLE slave, starting just after an edge. Returns just
   // after the edge that follows the ack pulse, with the slave back in IDLE.
   task automatic beat(input bit w4, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input bit hold, output int lat, output int ack_cyc,
                       output logic [31:0] rd, output bit pulse_ok);
      int k;
      lat = 0; ack_cyc = 0; rd = 32'h0; pulse_ok = 1'b0;
      if (w4) begin m4.req = 1'b1; m4.cmd = wr; m4.addr = a; m4.wdata = d; end
      else    begin m1.req = 1'b1; m1.cmd = wr; m1.addr = a; m1.wdata = d; end
      @(posedge PCLK); #1;
      if (!hold) begin
         if (w4) m4.req = 1'b0; else m1.req = 1'b0;
      end
      // scramble inputs after accept; the slave must ignore them
      if (w4) begin m4.addr = $urandom; m4.wdata = $urandom; m4.cmd = ~wr; end
      else    begin m1.addr = $urandom; m1.wdata = $urandom; m1.cmd = ~wr; end
      k = 0;
      while (lat == 0 && k < 20) begin
         @(posedge PCLK); #1;
         k++;
         if (w4 ? m4.ack : m1.ack) lat = k;
      end
      if (lat == 0) return;
      ack_cyc = cyc;
      rd = w4 ? m4.rdata : m1.rdata;
      @(posedge PCLK); #1;
      pulse_ok = !(w4 ? m4.ack : m1.ack);
   endtask

   task automatic test_reset();
      int lat, ac; logic [31:0] rd; bit po;
      m1.req = 1'b0; m1.cmd = 1'b0; m1.addr = 32'h0; m1.wdata = 32'h0;
      m4.req = 1'b0; m4.cmd = 1'b0; m4.addr = 32'h0; m4.wdata = 32'h0;
      clear_refs();
      PRESETN = 1'b0;
      repeat (3) @(posedge PCLK);
      #1 PRESETN = 1'b1;
      @(posedge PCLK); #1;
      checks++; if (m1.ack !== 1'b0) begin errors++; $display("FAIL reset_ack1: got %b expected 0", m1.ack); end
      checks++; if (m1.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata1: got %h expected 0", m1.rdata); end
      checks++; if (m4.ack !== 1'b0) begin errors++; $display("FAIL reset_ack4: got %b expected 0", m4.ack); end
      checks++; if (m4.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata4: got %h expected 0", m4.rdata); end
      beat(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, lat, ac, rd, po);
      checks++; if (!lat_ok(lat, 1)) begin errors++; $display("FAIL reset_read_lat: got %0d expected 1", lat); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_read_data: got %h expected 0", rd); end
   endtask

   task automatic test_single();
      int lat, ac; logic [31:0] rd; bit po;
      beat(1'b0, 1'b1, 32'h0000_0005, 32'hDEADBEEF, 1'b0, lat, ac, rd, po);
      ref1[5] = 32'hDEADBEEF;
      checks++; if (!lat_ok(lat, 1)) begin errors++; $display("FAIL single_wr_lat: got %0d expected 1", lat); end
      checks++; if (!po) begin errors++; $display("FAIL single_wr_pulse: ack still high after one cycle"); end
      checks++; if (rd !== last_rd1) begin errors++; $display("FAIL single_wr_rdata_held: got %h expected %h", rd, last_rd1); end
      repeat (2) @(posedge PCLK); #1;
      beat(1'b0, 1'b0, 32'h8000_0005, 32'h0, 1'b0, lat, ac, rd, po);
      last_rd1 = ref1[5];
      checks++; if (!lat_ok(lat, 1)) begin errors++; $display("FAIL single_rd_lat: got %0d expected 1", lat); end
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rd_alias: got %h expected deadbeef", rd); end
   endtask

   task automatic test_burst();
      int lat, ac, prev_ac; logic [31:0] rd; bit po;
      logic [31:0] vals [4];
      vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;
      for (int pass = 0; pass < 2; pass++) begin
         prev_ac = 0;
         for (int i = 0; i < 4; i++) begin
            beat(1'b0, pass == 0, 32'h20 + i, vals[i], i != 3, lat, ac, rd, po);
            if (pass == 0) ref1[8'h20 + i] = vals[i];
            else last_rd1 = ref1[8'h20 + i];
            checks++; if (!lat_ok(lat, 1)) begin errors++; $display("FAIL burst_lat[%0d.%0d]: got %0d expected 1", pass, i, lat); end
            checks++; if (!po) begin errors++; $display("FAIL burst_pulse[%0d.%0d]: ack wider than one cycle", pass, i); end
            if (i > 0) begin
               checks++;
               if (ac - prev_ac !== lat + 2) begin
                  errors++; $display("FAIL burst_gap[%0d.%0d]: got %0d expected %0d", pass, i, ac - prev_ac, lat + 2);
               end
            end
            if (pass == 1) begin
               checks++; if (rd !== vals[i]) begin errors++; $display("FAIL burst_rd[%0d]: got %h expected %h", i, rd, vals[i]); end
            end
            prev_ac = ac;
         end
      end
   endtask

   task automatic test_delay4();
      int lat, ac; logic [31:0] rd; bit po;
      beat(1'b1, 1'b1, 32'h3, 32'h0BADC0DE, 1'b0, lat, ac, rd, po);
      ref4[3] = 32'h0BADC0DE;
      checks++; if (!lat_ok(lat, 4)) begin errors++; $display("FAIL d4_wr_lat: got %0d expected 4", lat); end
      checks++; if (rd !== last_rd4) begin errors++; $display("FAIL d4_wr_rdata_held: got %h expected %h", rd, last_rd4); end
      @(posedge PCLK); #1;
      beat(1'b1, 1'b0, 32'h3, 32'h0, 1'b0, lat, ac, rd, po);
      last_rd4 = ref4[3];
      checks++; if (!lat_ok(lat, 4)) begin errors++; $display("FAIL d4_rd_lat: got %0d expected 4", lat); end
      checks++; if (!po) begin errors++; $display("FAIL d4_rd_pulse: ack wider than one cycle"); end
      checks++; if (rd !== 32'h0BADC0DE) begin errors++; $display("FAIL d4_rd_data: got %h expected 0badc0de", rd); end
   endtask

   task automatic test_reset_mid();
      int lat, ac, seen; logic [31:0] rd; bit po;
      m4.req = 1'b1; m4.cmd = 1'b1; m4.addr = 32'h7; m4.wdata = 32'hCAFEF00D;
      @(posedge PCLK); #1;
      m4.req = 1'b0;
      PRESETN = 1'b0;
      clear_refs();
      #1;
      checks++; if (m4.ack !== 1'b0) begin errors++; $display("FAIL mid_reset_ack: got %b expected 0", m4.ack); end
      #2 PRESETN = 1'b1;
      seen = 0;
      repeat (6) begin
         @(posedge PCLK); #1;
         if (m4.ack || m1.ack) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL mid_reset_no_ack: got %0d acks expected 0", seen); end
      beat(1'b1, 1'b0, 32'h7, 32'h0, 1'b0, lat, ac, rd, po);
      checks++; if (!lat_ok(lat, 4)) begin errors++; $display("FAIL mid_reset_rd_lat: got %0d expected 4", lat); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mid_reset_rd7: got %h expected 0", rd); end
      beat(1'b0, 1'b0, 32'h5, 32'h0, 1'b0, lat, ac, rd, po);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mid_reset_rd5: got %h expected 0", rd); end
   endtask

   task automatic test_random();
      int lat, ac, prev_ac; logic [31:0] rd, a, d; bit po, wr, hold, prev_hold;
      prev_hold = 1'b0; prev_ac = 0;
      for (int n = 0; n < 50; n++) begin
         wr = $urandom_range(0, 1);
         a = {$urandom_range(0, 255), 20'h0, 4'($urandom_range(0, 15))};
         d = $urandom;
         hold = (n != 49) && ($urandom_range(0, 1) == 1);
         beat(1'b0, wr, a, d, hold, lat, ac, rd, po);
         checks++; if (!lat_ok(lat, 1)) begin errors++; $display("FAIL rnd_lat[%0d]: got %0d expected 1..4", n, lat); end
         checks++; if (!po) begin errors++; $display("FAIL rnd_pulse[%0d]: ack wider than one cycle", n); end
         if (wr) begin
            checks++; if (rd !== last_rd1) begin errors++; $display("FAIL rnd_wr_rdata_held[%0d]: got %h expected %h", n, rd, last_rd1); end
            ref1[a[7:0]] = d;
         end else begin
            checks++; if (rd !== ref1[a[7:0]]) begin errors++; $display("FAIL rnd_rd[%0d]: got %h expected %h", n, rd, ref1[a[7:0]]); end
            last_rd1 = ref1[a[7:0]];
         end
         if (prev_hold) begin
            checks++; if (ac - prev_ac !== lat + 2) begin errors++; $display("FAIL rnd_gap[%0d]: got %0d expected %0d", n, ac - prev_ac, lat + 2); end
         end
         prev_hold = hold; prev_ac = ac;
         if (!hold && $urandom_range(0, 1) == 1) begin @(posedge PCLK); #1; end
      end
      checks++; if (dbl_ack !== 0) begin errors++; $display("FAIL no_double_ack: got %0d expected 0", dbl_ack); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_delay4();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
